// File: rtl/edsac_pkg.sv
// Shared EDSAC timing constants and sequence-control-tank FSM state encoding.
package edsac_pkg;

    localparam int MINOR_CYCLE = 18;
    localparam int ADDR_LO     = 1;
    localparam int ADDR_W      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND_INC,
        ST_PEND_LOAD,
        ST_INC,
        ST_LOAD
    } sct_state_t;

endpackage

// File: rtl/sct_sequencer_if.sv
// Main-control side of the sequence control tank: digit marker, requests, serial data and status.
interface sct_sequencer_if #(
    parameter int ADDR_W = edsac_pkg::ADDR_W
);
    logic              d0;
    logic              sct_one;
    logic              sct_in_gate;
    logic              sct_in;
    logic              sct_out;
    logic [ADDR_W-1:0] sct_addr;
    logic              busy;
    logic              done;

    modport master (
        output d0, sct_one, sct_in_gate, sct_in,
        input  sct_out, sct_addr, busy, done
    );

    modport slave (
        input  d0, sct_one, sct_in_gate, sct_in,
        output sct_out, sct_addr, busy, done
    );
endinterface

// File: rtl/sct_serial_cell.sv
// One-bit serial adder / load mux operating on the recirculating SCT bit stream.
module sct_serial_cell (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic load_mode,
    input  logic first,
    input  logic in_field,
    input  logic bit_in,
    input  logic load_bit,
    output logic bit_out
);
    logic carry;
    logic carry_eff;
    logic sum;

    // The increment is a carry-in of one injected at the address LSB.
    assign carry_eff = first | carry;
    assign sum       = bit_in ^ carry_eff;

    always_comb begin
        bit_out = bit_in;
        if (active && in_field) begin
            bit_out = load_mode ? load_bit : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else begin
            carry <= active && in_field && !load_mode && bit_in && carry_eff;
        end
    end
endmodule

// File: rtl/sct_sequencer.sv
// Sequence control tank: 18-digit recirculating register incremented or reloaded one minor cycle at a time.
module sct_sequencer #(
    parameter int MINOR_CYCLE = edsac_pkg::MINOR_CYCLE,
    parameter int ADDR_LO     = edsac_pkg::ADDR_LO,
    parameter int ADDR_W      = edsac_pkg::ADDR_W
) (
    input logic           clk,
    input logic           rst,
    sct_sequencer_if.slave bus
);
    import edsac_pkg::sct_state_t;
    import edsac_pkg::ST_IDLE;
    import edsac_pkg::ST_PEND_INC;
    import edsac_pkg::ST_PEND_LOAD;
    import edsac_pkg::ST_INC;
    import edsac_pkg::ST_LOAD;

    localparam int              CW       = $clog2(MINOR_CYCLE);
    localparam logic [CW-1:0]   DIG_LO   = CW'(ADDR_LO);
    localparam logic [CW-1:0]   DIG_HI   = CW'(ADDR_LO + ADDR_W - 1);
    localparam logic [CW-1:0]   DIG_LAST = CW'(MINOR_CYCLE - 1);
    localparam logic [CW:0]     MC_W     = (CW + 1)'(MINOR_CYCLE);

    sct_state_t             state;
    sct_state_t             state_n;
    logic                   q_inc;
    logic                   q_inc_n;
    logic                   q_load;
    logic                   q_load_n;
    logic [CW-1:0]          dcnt;
    logic [CW-1:0]          digit;
    logic [MINOR_CYCLE-1:0] sr;
    logic [MINOR_CYCLE-1:0] sr_rot;
    logic [MINOR_CYCLE-1:0] sr_al;
    logic [ADDR_W-1:0]      addr;
    logic                   resync;
    logic                   starting;
    logic                   active;
    logic                   load_mode;
    logic                   last;
    logic                   in_field;
    logic                   cell_bit;

    assign digit     = bus.d0 ? '0 : dcnt;
    assign resync    = bus.d0 && (dcnt != '0);
    assign last      = (digit == DIG_LAST);
    assign in_field  = (digit >= DIG_LO) && (digit <= DIG_HI);
    assign starting  = bus.d0 && (state == ST_PEND_INC || state == ST_PEND_LOAD);
    assign active    = (state == ST_INC) || (state == ST_LOAD) || starting;
    assign load_mode = (state == ST_LOAD) || (bus.d0 && state == ST_PEND_LOAD);

    // On an early d0 the stream is rotated so sr[0] is digit 0 again, and the
    // address field is restored from the committed copy to abort any partial update.
    always_comb begin
        sr_rot = (sr << dcnt) | (sr >> (MC_W - {1'b0, dcnt}));
        sr_al  = sr;
        if (resync) begin
            sr_al                    = sr_rot;
            sr_al[ADDR_LO +: ADDR_W] = addr;
        end
    end

    sct_serial_cell u_cell (
        .clk       (clk),
        .rst       (rst),
        .active    (active),
        .load_mode (load_mode),
        .first     (digit == DIG_LO),
        .in_field  (in_field),
        .bit_in    (sr_al[0]),
        .load_bit  (bus.sct_in),
        .bit_out   (cell_bit)
    );

    always_comb begin
        state_n  = state;
        q_inc_n  = q_inc;
        q_load_n = q_load;
        if (active) begin
            if (bus.sct_in_gate) begin
                q_load_n = 1'b1;
                q_inc_n  = 1'b0;
            end else if (bus.sct_one && !q_load) begin
                q_inc_n = 1'b1;
            end
        end
        unique case (state)
            ST_IDLE: begin
                if (bus.sct_in_gate)  state_n = ST_PEND_LOAD;
                else if (bus.sct_one) state_n = ST_PEND_INC;
            end
            ST_PEND_INC: begin
                if (bus.d0)               state_n = ST_INC;
                else if (bus.sct_in_gate) state_n = ST_PEND_LOAD;
            end
            ST_PEND_LOAD: begin
                if (bus.d0) state_n = ST_LOAD;
            end
            ST_INC, ST_LOAD: begin
                if (last) begin
                    state_n  = q_load_n ? ST_PEND_LOAD : (q_inc_n ? ST_PEND_INC : ST_IDLE);
                    q_load_n = 1'b0;
                    q_inc_n  = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            q_inc  <= 1'b0;
            q_load <= 1'b0;
            dcnt   <= '0;
            sr     <= '0;
            addr   <= '0;
        end else begin
            state  <= state_n;
            q_inc  <= q_inc_n;
            q_load <= q_load_n;
            dcnt   <= last ? '0 : digit + 1'b1;
            sr     <= {cell_bit, sr_al[MINOR_CYCLE-1:1]};
            // At digit 17 sr[k] holds digit k-1, so the new address sits one place up.
            if (active && last) begin
                addr <= sr_al[ADDR_LO+1 +: ADDR_W];
            end
        end
    end

    assign bus.sct_out  = sr_al[0];
    assign bus.sct_addr = addr;
    assign bus.busy     = active;
    assign bus.done     = active && last;
endmodule

// File: tb/tb_sct_sequencer.sv
// Self-checking bench for sct_sequencer: directed vectors, corner sequences and randomized traffic.
module tb_sct_sequencer;
    localparam int MC = edsac_pkg::MINOR_CYCLE;
    localparam int AL = edsac_pkg::ADDR_LO;
    localparam int AW = edsac_pkg::ADDR_W;

    typedef struct {
        bit            one;
        bit            gate;
        logic [AW-1:0] val;
        logic [AW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sct_sequencer_if #(.ADDR_W(AW)) bus ();

    sct_sequencer #(.MINOR_CYCLE(MC), .ADDR_LO(AL), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            ph;
    int            cur_ph;
    int            done_cnt;
    bit            noise_en;
    logic [AW-1:0] drv;
    logic [MC-1:0] cap;

    // Reference: the tank holds one address; an operation is one whole minor cycle
    // that either adds one modulo 2^AW or replaces it with the serial bits seen.
    int m_cnt, m_addr, m_pend, m_lval;
    bit m_act, m_kind, m_qi, m_ql;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_addr = 0; m_pend = 0; m_lval = 0;
        m_act = 0; m_kind = 0; m_qi = 0; m_ql = 0;
    endtask

    task automatic model_step(input bit d0, input bit one, input bit gate, input bit sin, input bit r);
        int dig;
        bit start, act, kind;
        dig   = d0 ? 0 : m_cnt;
        start = d0 && (m_pend != 0);
        act   = m_act || start;
        kind  = m_act ? m_kind : (m_pend == 2);
        check("busy", 32'(bus.busy), 32'(act));
        check("done", 32'(bus.done), 32'(act && dig == MC - 1));
        check("sct_addr", 32'(bus.sct_addr), 32'(m_addr));
        check("sct_out", 32'(bus.sct_out), 32'(((m_addr << AL) >> dig) & 1));
        if (r) begin
            model_reset();
        end else begin
            if (act) begin
                if (gate) begin m_ql = 1; m_qi = 0; end
                else if (one && !m_ql) m_qi = 1;
                if (start) begin m_act = 1; m_kind = kind; m_pend = 0; end
                if (d0) m_lval = 0;
                if (kind && dig >= AL && dig < AL + AW) m_lval = m_lval | (int'(sin) << (dig - AL));
                if (dig == MC - 1) begin
                    m_addr = kind ? m_lval : (m_addr + 1) % (1 << AW);
                    m_act  = 0;
                    m_pend = m_ql ? 2 : (m_qi ? 1 : 0);
                    m_ql   = 0;
                    m_qi   = 0;
                end
            end else begin
                if (gate) m_pend = 2;
                else if (one && m_pend != 2) m_pend = 1;
            end
            m_cnt = (dig == MC - 1) ? 0 : dig + 1;
        end
    endtask

    task automatic tick(input bit one, input bit gate, input bit r);
        bit d0, sin;
        @(posedge clk);
        #1;
        d0 = (ph == 0);
        if (ph >= AL && ph < AL + AW) sin = drv[ph - AL];
        else sin = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.d0 = d0; bus.sct_one = one; bus.sct_in_gate = gate; bus.sct_in = sin; rst = r;
        cur_ph = ph;
        @(negedge clk);
        if (bus.done === 1'b1) done_cnt++;
        cap[cur_ph] = bus.sct_out;
        model_step(d0, one, gate, sin, r);
        ph = (ph + 1) % MC;
    endtask

    task automatic go_to(input int p);
        int g = 0;
        while (ph != p && g < 2 * MC) begin
            tick(1'b0, 1'b0, 1'b0);
            g++;
        end
    endtask

    task automatic minor();
        repeat (MC) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_op(input bit one, input bit gate, input logic [AW-1:0] val);
        go_to(7);
        drv = val;
        tick(one, gate, 1'b0);
        go_to(0);
        minor();
    endtask

    vec_t vecs[10];

    initial begin
        int busy_cnt, done_at;
        bus.d0 = 0; bus.sct_one = 0; bus.sct_in_gate = 0; bus.sct_in = 0;
        rst = 1'b1; ph = 0; drv = '0; noise_en = 0; done_cnt = 0; cap = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.sct_addr), 32'd0);
        check("rst_out", 32'(bus.sct_out), 32'd0);
        model_reset();

        // First increment after reset: 18 busy digits, done on digit 17.
        go_to(5);
        tick(1'b1, 1'b0, 1'b0);
        go_to(0);
        busy_cnt = 0; done_at = -1;
        repeat (MC) begin
            tick(1'b0, 1'b0, 1'b0);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) done_at = cur_ph;
        end
        check("inc1_busy_len", 32'(busy_cnt), 32'(MC));
        check("inc1_done_digit", 32'(done_at), 32'(MC - 1));
        tick(1'b0, 1'b0, 1'b0);
        check("inc1_busy_after", 32'(bus.busy), 32'd0);
        check("inc1_addr", 32'(bus.sct_addr), 32'd1);

        vecs[0] = '{1'b0, 1'b1, 10'h3FF, 10'h3FF};
        vecs[1] = '{1'b1, 1'b0, 10'h000, 10'h000};
        vecs[2] = '{1'b1, 1'b1, 10'h155, 10'h155};
        vecs[3] = '{1'b1, 1'b0, 10'h000, 10'h156};
        vecs[4] = '{1'b0, 1'b1, 10'h2AA, 10'h2AA};
        vecs[5] = '{1'b1, 1'b0, 10'h3FF, 10'h2AB};
        vecs[6] = '{1'b0, 1'b1, 10'h000, 10'h000};
        vecs[7] = '{1'b1, 1'b0, 10'h000, 10'h001};
        vecs[8] = '{1'b0, 1'b1, 10'h1FF, 10'h1FF};
        vecs[9] = '{1'b1, 1'b0, 10'h000, 10'h200};
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].one, vecs[i].gate, vecs[i].val);
            minor();
            check($sformatf("vec%0d_addr", i), 32'(bus.sct_addr), 32'(vecs[i].exp));
            check($sformatf("vec%0d_word", i), 32'(cap), 32'(vecs[i].exp) << AL);
        end

        // Queued increments: one while busy runs next, duplicates merge.
        do_op(1'b0, 1'b1, 10'd7);
        go_to(3);
        tick(1'b1, 1'b0, 1'b0);
        go_to(0);
        go_to(5);
        tick(1'b1, 1'b0, 1'b0);
        go_to(0);
        go_to(1);
        check("q_addr8", 32'(bus.sct_addr), 32'd8);
        go_to(4);
        tick(1'b1, 1'b0, 1'b0);
        go_to(9);
        tick(1'b1, 1'b0, 1'b0);
        go_to(0);
        go_to(1);
        check("q_addr9", 32'(bus.sct_addr), 32'd9);
        check("q_busy9", 32'(bus.busy), 32'd1);
        go_to(0);
        go_to(1);
        check("q_addr10", 32'(bus.sct_addr), 32'd10);
        check("q_busy10", 32'(bus.busy), 32'd0);

        // Reset in the middle of a load.
        do_op(1'b0, 1'b1, 10'd4);
        go_to(3);
        drv = 10'h3FF;
        tick(1'b0, 1'b1, 1'b0);
        go_to(0);
        go_to(9);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("rstmid_addr", 32'(bus.sct_addr), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);

        // Early d0 at digit 12 restarts the increment.
        do_op(1'b0, 1'b1, 10'd20);
        go_to(3);
        tick(1'b1, 1'b0, 1'b0);
        go_to(0);
        go_to(12);
        ph = 0;
        done_cnt = 0;
        repeat (2 * MC) tick(1'b0, 1'b0, 1'b0);
        check("resync_done_cnt", 32'(done_cnt), 32'd1);
        check("resync_addr", 32'(bus.sct_addr), 32'd21);

        noise_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if (ph == 0) drv = AW'($urandom);
            if ($urandom_range(0, 199) == 0) ph = 0;
            tick($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
